// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster sequencer for the 3x3 Sobel datapath.
// Walks every interior pixel of an IMG_W x IMG_H row-major image, fetches
// its nine neighbours through the single read port and offers them as one
// packed window to the gradient core over valid/ready.
// Optional build macro: SOBEL_CTRL_STALL_CNT_EN enables the backpressure
// counter on stall_cnt; without it stall_cnt is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; i=1, j=1
// S_FETCH  | nine read cycles, q=0..8, slot q-1 captured for q>=1
// S_LAST   | no read; last slot (P8) captured
// S_PRESENT| window offered; held until win_ready
// S_DONE   | one-cycle done pulse, then back to S_IDLE

module sobel_window_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [ADDR_W-1:0]    win_addr,
  output logic [15:0]          stall_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_PRESENT, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] J_LAST = ADDR_W'(IMG_W - 2);

  state_t              state, state_nxt;
  logic [3:0]          q;
  logic [ADDR_W-1:0]   row_i, col_j;
  logic [ADDR_W-1:0]   centre, fetch_addr;
  logic [PIX_W-1:0]    slot [9];
  logic                start_ok, xfer, last_win;

  assign centre   = row_i * W_A + col_j;
  assign start_ok = (state == S_IDLE) && start;
  assign xfer     = (state == S_PRESENT) && win_ready;
  assign last_win = (row_i == I_LAST) && (col_j == J_LAST);

  // Neighbour address for fetch step q: row offset q/3, column offset q%3.
  always_comb begin
    fetch_addr = centre;
    case (q)
      4'd0:    fetch_addr = centre - W_A - ONE_A;
      4'd1:    fetch_addr = centre - W_A;
      4'd2:    fetch_addr = centre - W_A + ONE_A;
      4'd3:    fetch_addr = centre - ONE_A;
      4'd4:    fetch_addr = centre;
      4'd5:    fetch_addr = centre + ONE_A;
      4'd6:    fetch_addr = centre + W_A - ONE_A;
      4'd7:    fetch_addr = centre + W_A;
      4'd8:    fetch_addr = centre + W_A + ONE_A;
      default: fetch_addr = centre;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and all handshake/read-port outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    win_valid = 1'b0;
    win_addr  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = fetch_addr;
        if (q == 4'd8) state_nxt = S_LAST;
      end
      S_LAST: begin
        busy      = 1'b1;
        state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        win_addr  = centre;
        if (win_ready) state_nxt = last_win ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch step counter, raster position and window slot capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      row_i <= ONE_A;
      col_j <= ONE_A;
      for (int k = 0; k < 9; k++) slot[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            q     <= '0;
            row_i <= ONE_A;
            col_j <= ONE_A;
          end
        end
        S_FETCH: begin
          q <= q + 4'd1;
          if (q != 4'd0) slot[q - 4'd1] <= rd_data;
        end
        S_LAST: begin
          slot[8] <= rd_data;
          q       <= '0;
        end
        S_PRESENT: begin
          if (xfer) begin
            q <= '0;
            if (col_j == J_LAST) begin
              col_j <= ONE_A;
              row_i <= row_i + ONE_A;
            end else begin
              col_j <= col_j + ONE_A;
            end
          end
        end
        S_DONE: begin
          row_i <= ONE_A;
          col_j <= ONE_A;
        end
        default: q <= '0;
      endcase
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_pack
    assign win_data[g*PIX_W +: PIX_W] = slot[g];
  end

`ifdef SOBEL_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of presented-but-not-accepted cycles for this frame.
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      stall_q <= '0;
    else if ((state == S_PRESENT) && !win_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: a 64x64 instance (abort/restart, full frame,
// start re-pulse) and a 5x4 instance (address order, backpressure).
// Windows expected are queued at stimulus time; monitors pop on transfer.

module tb_sobel_window_ctrl;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0;
  int fails = 0;

  logic            rst_a, start_a, busy_a, done_a, rd_en_a, win_valid_a, win_ready_a;
  logic [AW-1:0]   rd_addr_a, win_addr_a;
  logic [7:0]      rd_data_a;
  logic [71:0]     win_data_a;
  logic [15:0]     stall_a;

  logic            rst_b, start_b, busy_b, done_b, rd_en_b, win_valid_b, win_ready_b;
  logic [AW-1:0]   rd_addr_b, win_addr_b;
  logic [7:0]      rd_data_b;
  logic [71:0]     win_data_b;
  logic [15:0]     stall_b;

  sobel_window_ctrl #(.IMG_W(64), .IMG_H(64), .ADDR_W(AW), .PIX_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .win_valid(win_valid_a), .win_ready(win_ready_a), .win_data(win_data_a),
    .win_addr(win_addr_a), .stall_cnt(stall_a));

  sobel_window_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(AW), .PIX_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .win_valid(win_valid_b), .win_ready(win_ready_b), .win_data(win_data_b),
    .win_addr(win_addr_b), .stall_cnt(stall_b));

  // Ramp-image memories: one-cycle read latency, poison value when idle.
  always @(posedge clk) rd_data_a <= rd_en_a ? rd_addr_a[7:0] : 8'hEE;
  always @(posedge clk) rd_data_b <= rd_en_b ? rd_addr_b[7:0] : 8'hEE;

  logic [83:0] sb_a[$];
  logic [83:0] sb_b[$];
  int          rdq_b[$];
  int xfer_a = 0, done_cnt_a = 0, done_cyc_a = 0, last_addr_a = 0, p_a = 0;
  int xfer_b = 0, done_cnt_b = 0, done_cyc_b = 0, p_b = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] ramp_win(input int c, input int w);
    logic [71:0] r;
    int p;
    r = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        p = c + (dr - 1) * w + (dc - 1);
        r[(dr*3+dc)*8 +: 8] = p[7:0];
      end
    return r;
  endfunction

  // Monitor A: pop and compare on every transfer, track done.
  always @(negedge clk) begin
    logic [83:0] e;
    if (!rst_a) begin
      if (win_valid_a && win_ready_a) begin
        if (sb_a.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_unexpected_win: got addr %0d expected no window", win_addr_a);
        end else begin
          e = sb_a.pop_front();
          chk("a_win_addr", win_addr_a, e[83:72]);
          chk("a_win_data", win_data_a, e[71:0]);
        end
        xfer_a++;
        last_addr_a = win_addr_a;
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc - p_a + 1;
      end
    end
  end

  // Monitor B: same, plus read-address log.
  always @(negedge clk) begin
    logic [83:0] e;
    if (!rst_b) begin
      if (rd_en_b) rdq_b.push_back(int'(rd_addr_b));
      if (win_valid_b && win_ready_b) begin
        if (sb_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected_win: got addr %0d expected no window", win_addr_b);
        end else begin
          e = sb_b.pop_front();
          chk("b_win_addr", win_addr_b, e[83:72]);
          chk("b_win_data", win_data_b, e[71:0]);
        end
        xfer_b++;
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc - p_b + 1;
      end
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    p_a = cyc;
  endtask

  task automatic pulse_start_b();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    p_b = cyc;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (done_cnt_a == 0 && n < budget) begin @(negedge clk); n++; end
    if (done_cnt_a == 0) begin
      tests++; fails++;
      $display("FAIL a_done_timeout: got no done in %0d cycles expected done", budget);
    end
  endtask

  task automatic wait_done_b(input int budget);
    int n = 0;
    while (done_cnt_b == 0 && n < budget) begin @(negedge clk); n++; end
    if (done_cnt_b == 0) begin
      tests++; fails++;
      $display("FAIL b_done_timeout: got no done in %0d cycles expected done", budget);
    end
  endtask

  initial begin
    int b_addrs [6] = '{6, 7, 8, 11, 12, 13};
    int b_rd    [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int a_rd    [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
    logic [71:0] a_first = 72'h82_81_80_42_41_40_02_01_00;
    logic [71:0] snap_d;
    logic [AW-1:0] snap_a;
    int exp_stall;
    int n;
`ifdef SOBEL_CTRL_STALL_CNT_EN
    exp_stall = 7;
`else
    exp_stall = 0;
`endif

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    win_ready_a = 1'b1; win_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset_ctrl", {busy_a, done_a, rd_en_a, win_valid_a, rd_addr_a, win_addr_a, stall_a}, '0);
    chk("a_reset_data", win_data_a, '0);
    chk("b_reset_ctrl", {busy_b, done_b, rd_en_b, win_valid_b, rd_addr_b, win_addr_b, stall_b}, '0);
    @(posedge clk); #1 rst_a = 1'b0; rst_b = 1'b0;

    // 5x4 frame, ready held high (also while fetching).
    foreach (b_addrs[k]) sb_b.push_back({AW'(b_addrs[k]), ramp_win(b_addrs[k], 5)});
    rdq_b.delete(); xfer_b = 0; done_cnt_b = 0;
    pulse_start_b();
    wait_done_b(300);
    chk("b_windows", xfer_b, 6);
    chk("b_done_cycle", done_cyc_b, 67);
    chk("b_rd_count", rdq_b.size(), 54);
    if (rdq_b.size() >= 9)
      for (int k = 0; k < 9; k++) chk("b_rd_addr", rdq_b[k], b_rd[k]);
    chk("b_stall_f1", stall_b, 0);
    chk("b_sb_empty_f1", sb_b.size(), 0);

    // 5x4 frame with a 7-cycle stall on the third window.
    foreach (b_addrs[k]) sb_b.push_back({AW'(b_addrs[k]), ramp_win(b_addrs[k], 5)});
    xfer_b = 0; done_cnt_b = 0;
    pulse_start_b();
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(win_valid_b && win_addr_b == AW'(8)) && n < 100);
    chk("b_third_win_seen", win_addr_b, 8);
    win_ready_b = 1'b0;
    snap_d = win_data_b;
    snap_a = win_addr_b;
    repeat (7) begin
      @(negedge clk);
      chk("b_stall_addr", win_addr_b, snap_a);
      chk("b_stall_data", win_data_b, snap_d);
      chk("b_stall_rd_en", rd_en_b, 0);
      chk("b_stall_valid", win_valid_b, 1);
    end
    @(posedge clk); #1 win_ready_b = 1'b1;
    wait_done_b(300);
    chk("b_windows_f2", xfer_b, 6);
    chk("b_done_cycle_f2", done_cyc_b, 74);
    chk("b_stall_at_done", stall_b, exp_stall);
    repeat (5) @(negedge clk);
    chk("b_stall_held", stall_b, exp_stall);
    chk("b_sb_empty_f2", sb_b.size(), 0);
    pulse_start_b();
    @(negedge clk);
    chk("b_stall_cleared", stall_b, 0);
    chk("b_busy_restart", busy_b, 1);
    @(posedge clk); #1 rst_b = 1'b1;
    @(posedge clk); #1 rst_b = 1'b0;

    // 64x64: reset in cycle 20 aborts without done.
    sb_a.push_back({AW'(65), a_first});
    xfer_a = 0; done_cnt_a = 0;
    pulse_start_a();
    repeat (19) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    @(negedge clk);
    chk("a_abort_ctrl", {busy_a, done_a, rd_en_a, win_valid_a, rd_addr_a, win_addr_a, stall_a}, '0);
    chk("a_abort_data", win_data_a, '0);
    chk("a_abort_xfers", xfer_a, 1);
    repeat (30) @(negedge clk);
    chk("a_abort_no_done", done_cnt_a, 0);
    chk("a_abort_busy", busy_a, 0);

    // 64x64 full frame with a second start pulse in cycle 50.
    sb_a.push_back({AW'(65), a_first});
    for (int i = 1; i <= 62; i++)
      for (int j = 1; j <= 62; j++)
        if (!(i == 1 && j == 1)) sb_a.push_back({AW'(i*64 + j), ramp_win(i*64 + j, 64)});
    xfer_a = 0; done_cnt_a = 0;
    pulse_start_a();
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("a_busy_early", busy_a, 1);
      chk("a_rd_en_timing", rd_en_a, (c <= 9));
      chk("a_valid_timing", win_valid_a, (c == 11));
      if (c <= 9) chk("a_rd_addr_first", rd_addr_a, a_rd[c-1]);
    end
    repeat (39) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(50000);
    chk("a_windows", xfer_a, 3844);
    chk("a_last_addr", last_addr_a, 4030);
    chk("a_done_cycle", done_cyc_a, 42285);
    chk("a_sb_empty", sb_a.size(), 0);
    repeat (20) @(negedge clk);
    chk("a_done_once", done_cnt_a, 1);
    chk("a_idle_busy", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
